// File: rtl/dco_fll_pkg.sv
// dco_fll_pkg: shared types and constants for the DCO frequency-locked-loop controller.
//   state_e    : controller states
//   CODE_W     : width of the DCO control code
//   bit_cycles : clk cycles spent on one SAR bit (SET + SETTLE + MEASURE + DECIDE)
package dco_fll_pkg;

  localparam int CODE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SET,
    SETTLE,
    MEASURE,
    DECIDE,
    DONE,
    TRACK
  } state_e;

  function automatic int bit_cycles(input int settle_cycles, input int window_cycles);
    return settle_cycles + window_cycles + 2;
  endfunction

endpackage

// File: rtl/dco_fll_ctrl_edge_counter.sv
// dco_edge_counter: saturating DCO edge counter plus a shared settle/window down-timer.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   cnt_clr_i      : clear the edge count (takes priority over counting)
//   cnt_en_i       : count enable; each edge_i pulse adds one while enabled
//   edge_i         : one-cycle pulse per synchronised DCO edge
//   tmr_load_i     : load the timer with tmr_val_i
//   tmr_val_i      : timer load value (cycles remaining minus one)
//   count_o        : current edge count, sticks at all-ones
//   tmr_zero_o     : timer has reached zero (terminal count)
module dco_edge_counter
  import dco_fll_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int TMR_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cnt_clr_i,
  input  logic             cnt_en_i,
  input  logic             edge_i,
  input  logic             tmr_load_i,
  input  logic [TMR_W-1:0] tmr_val_i,
  output logic [CNT_W-1:0] count_o,
  output logic             tmr_zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [TMR_W-1:0] tmr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tmr_q <= '0;
    end else begin
      if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (cnt_en_i && edge_i && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (tmr_load_i) begin
        tmr_q <= tmr_val_i;
      end else if (tmr_q != '0) begin
        tmr_q <= tmr_q - TMR_W'(1);
      end
    end
  end

  assign count_o    = cnt_q;
  assign tmr_zero_o = (tmr_q == '0);

endmodule

// File: rtl/dco_fll_ctrl.sv
// dco_fll_ctrl: SAR frequency-locked-loop controller for an 8-bit DCO code.
// Counts DCO edges over a fixed window and binary-searches the code so the
// count approaches target_count_i.
//   clk_i, rst_i    : clock, synchronous active-high reset
//   start_i         : begin a search (only honoured in IDLE)
//   abort_i         : return to IDLE next edge, code is kept
//   target_count_i  : desired edges per window, latched on start
//   dco_edge_i      : one-cycle pulse per synchronised DCO edge
//   dco_code_o      : code driven to the DCO
//   busy_o          : high outside IDLE
//   done_o          : one-cycle pulse when a search completes
//   locked_o        : final |count - target| <= TOL
//   last_count_o    : count of the most recent completed window
// Build option: define DCO_FLL_TRACK_EN to keep tracking after the search.
//
//   state   | meaning
//   IDLE    | waiting for start
//   SET     | set trial bit idx
//   SETTLE  | let the DCO settle
//   MEASURE | count edges over the window
//   DECIDE  | keep/clear trial bit, next bit or finish
//   DONE    | pulse done, report lock
//   TRACK   | +/-1 code step after each window (option build)
module dco_fll_ctrl
  import dco_fll_pkg::*;
#(
  parameter int WINDOW_CYCLES = 256,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 16,
  parameter int TOL           = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [CNT_W-1:0]  target_count_i,
  input  logic              dco_edge_i,
  output logic [CODE_W-1:0] dco_code_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              locked_o,
  output logic [CNT_W-1:0]  last_count_o
);

  localparam int TMR_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES - 1 : SETTLE_CYCLES - 1;
  localparam int TMR_W   = (TMR_MAX < 1) ? 1 : $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WINDOW_LD = TMR_W'(WINDOW_CYCLES - 1);

  state_e            state_q;
  logic [2:0]        idx_q;
  logic [CODE_W-1:0] code_q;
  logic              busy_q;
  logic              done_q;
  logic              locked_q;
  logic [CNT_W-1:0]  target_q;
  logic [CNT_W-1:0]  last_q;
`ifdef DCO_FLL_TRACK_EN
  logic              trk_q;
`endif

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] diff;
  logic             in_tol;
  logic             tmr_zero;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             cnt_clr;
  logic             cnt_en;

  dco_edge_counter #(
    .CNT_W (CNT_W),
    .TMR_W (TMR_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .cnt_clr_i  (cnt_clr),
    .cnt_en_i   (cnt_en),
    .edge_i     (dco_edge_i),
    .tmr_load_i (tmr_load),
    .tmr_val_i  (tmr_val),
    .count_o    (count),
    .tmr_zero_o (tmr_zero)
  );

  // Every state that moves into SETTLE loads the settle time; the end of
  // SETTLE loads the window and clears the count for the new measurement.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = SETTLE_LD;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      SET, DONE, TRACK: tmr_load = 1'b1;
      SETTLE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = WINDOW_LD;
          cnt_clr  = 1'b1;
        end
      end
      MEASURE: cnt_en = 1'b1;
      default: ;
    endcase
  end

  assign diff   = (count > target_q) ? (count - target_q) : (target_q - count);
  assign in_tol = (diff <= CNT_W'(TOL));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= 3'd7;
      code_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      target_q <= '0;
      last_q   <= '0;
`ifdef DCO_FLL_TRACK_EN
      trk_q    <= 1'b0;
`endif
    end else if (abort_i) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
`ifdef DCO_FLL_TRACK_EN
      trk_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            // The code restarts from zero so stale low bits of an earlier
            // search cannot bias the binary search.
            target_q <= target_count_i;
            locked_q <= 1'b0;
            idx_q    <= 3'd7;
            code_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= SET;
          end
        end
        SET: begin
          code_q[idx_q] <= 1'b1;
          state_q       <= SETTLE;
        end
        SETTLE: begin
          if (tmr_zero) state_q <= MEASURE;
        end
        MEASURE: begin
`ifdef DCO_FLL_TRACK_EN
          if (tmr_zero) state_q <= trk_q ? TRACK : DECIDE;
`else
          if (tmr_zero) state_q <= DECIDE;
`endif
        end
        DECIDE: begin
          last_q <= count;
          if (count > target_q) code_q[idx_q] <= 1'b0;
          if (idx_q == 3'd0) begin
            // Lock is judged on the last measured window; the final code is
            // not measured again.
            done_q   <= 1'b1;
            locked_q <= in_tol;
            state_q  <= DONE;
          end else begin
            idx_q   <= idx_q - 3'd1;
            state_q <= SET;
          end
        end
        DONE: begin
`ifdef DCO_FLL_TRACK_EN
          trk_q   <= 1'b1;
          state_q <= SETTLE;
`else
          busy_q  <= 1'b0;
          state_q <= IDLE;
`endif
        end
`ifdef DCO_FLL_TRACK_EN
        TRACK: begin
          last_q   <= count;
          locked_q <= in_tol;
          if (!in_tol) begin
            if (count > target_q) begin
              if (code_q != '0) code_q <= code_q - CODE_W'(1);
            end else begin
              if (code_q != '1) code_q <= code_q + CODE_W'(1);
            end
          end
          state_q <= SETTLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dco_code_o   = code_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign locked_o     = locked_q;
  assign last_count_o = last_q;

endmodule

// File: tb/tb_dco_fll_ctrl.sv
module tb_dco_fll_ctrl;

  localparam int W = 512;
  localparam int S = 16;
  localparam int P = W + S + 2;
  localparam int N = 8 * P;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] target_count = 16'd0;
  logic        dco_edge = 1'b0;

  logic [7:0]  dco_code_o;
  logic        busy_o, done_o, locked_o;
  logic [15:0] last_count_o;

  logic [7:0]  code_b;
  logic        busy_b, done_b, locked_b;
  logic [7:0]  last_b;

  dco_fll_ctrl #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(16), .TOL(2)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .target_count_i(target_count), .dco_edge_i(dco_edge),
    .dco_code_o(dco_code_o), .busy_o(busy_o), .done_o(done_o),
    .locked_o(locked_o), .last_count_o(last_count_o)
  );

  // Narrow counter, zero tolerance: exercises saturation and strict lock.
  dco_fll_ctrl #(.WINDOW_CYCLES(W), .SETTLE_CYCLES(S), .CNT_W(8), .TOL(0)) dut_t0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .target_count_i(target_count[7:0]), .dco_edge_i(dco_edge),
    .dco_code_o(code_b), .busy_o(busy_b), .done_o(done_b),
    .locked_o(locked_b), .last_count_o(last_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DCO: phase accumulator, exactly gain*code+ofs edges in any W cycles of constant code.
  int gain = 2;
  int ofs = 0;
  int acc = 0;
  always @(negedge clk) begin
    acc = acc + gain * int'(dco_code_o) + ofs;
    if (acc >= W) begin
      acc = acc - W;
      dco_edge = 1'b1;
    end else begin
      dco_edge = 1'b0;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: search outcome per bit, plus schedule arithmetic.
  bit m_act = 1'b0;
  int m_s0 = 0;
  int m_ab = 0;
  int m_last0 = 0;
  bit m_lock = 1'b0;
  int step_code[8];
  int step_cnt[8];
  int e_code, e_last, e_busy, e_done, e_lock;

  task automatic plan(input int t, input int g);
    int code;
    int trial;
    int cnt;
    code = 0;
    cnt = 0;
    for (int j = 0; j < 8; j++) begin
      trial = code | (128 >> j);
      cnt = g * trial;
      if (cnt > 65535) cnt = 65535;
      if (cnt <= t) code = trial;
      step_code[j] = code;
      step_cnt[j] = cnt;
    end
    m_lock = ((cnt > t) ? (cnt - t) : (t - cnt)) <= 2;
  endtask

  task automatic model_eval(input int cy);
    int c, ce, j, r, prev;
    if (!m_act) begin
      e_code = 0; e_last = 0; e_busy = 0; e_done = 0; e_lock = 0;
      return;
    end
    c = cy - m_s0;
    ce = (c > m_ab) ? m_ab : c;
    if (ce <= N) begin
      j = (ce - 1) / P;
      r = (ce - 1) % P;
      prev = (j == 0) ? 0 : step_code[j-1];
      e_code = (r == 0) ? prev : (prev | (128 >> j));
      e_last = (j == 0) ? m_last0 : step_cnt[j-1];
      e_lock = 0;
      e_busy = 1;
      e_done = 0;
    end else begin
      e_code = step_code[7];
      e_last = step_cnt[7];
      e_lock = m_lock;
      e_busy = (ce == N + 1);
      e_done = (ce == N + 1);
    end
    if (c > m_ab) begin
      e_busy = 0; e_done = 0; e_lock = 0;
    end
  endtask

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      model_eval(cyc);
      chk("dco_code", dco_code_o, e_code);
      chk("last_count", last_count_o, e_last);
      chk("busy", busy_o, e_busy);
      chk("done", done_o, e_done);
      chk("locked", locked_o, e_lock);
    end
  end

  int n_done = 0;
  int last_done = 0;
  always @(negedge clk) begin
    if (done_o) begin
      n_done++;
      last_done = cyc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_search(input int t, input int g);
    gain = g;
    model_eval(cyc);
    m_last0 = e_last;
    plan(t, g);
    m_s0 = cyc;
    m_ab = 32'h3fff_ffff;
    m_act = 1'b1;
    target_count = 16'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Advance to cycle offset c_end; optionally inject ignored starts and target changes.
  task automatic run_to(input int c_end, input bit noise);
    while (cyc - m_s0 < c_end) begin
      if (noise) begin
        start = ((cyc - m_s0) < N) && ($urandom_range(0, 63) == 0);
        target_count = 16'($urandom);
      end
      tick();
    end
    start = 1'b0;
  endtask

  int nd0;
  int t_r, g_r;

  initial begin
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    tick();
    chk("rst_code", dco_code_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_locked", locked_o, 0);
    chk("rst_last", last_count_o, 0);
    chk("rst_t0_busy", busy_b, 0);
    chk("rst_t0_done", done_b, 0);

`ifdef DCO_FLL_TRACK_EN
    begin_search(100, 2);
    run_to(N + 1, 1'b0);
    chk("trk_done_cycle", last_done - m_s0, 4241);
    chk("trk_search_code", dco_code_o, 50);
    chk_en = 1'b0;
    ofs = 10;
    repeat (12 * (S + W + 1)) tick();
    chk("trk_code", dco_code_o, 46);
    chk("trk_locked", locked_o, 1);
    chk("trk_busy", busy_o, 1);
    chk("trk_last", last_count_o, 102);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("trk_abort_busy", busy_o, 0);
    chk("trk_abort_code", dco_code_o, 46);
`else
    nd0 = n_done;
    begin_search(100, 2);
    run_to(N + 3, 1'b1);
    chk("t100_done_cycle", last_done - m_s0, 4241);
    chk("t100_done_pulses", n_done - nd0, 1);
    chk("t100_code", dco_code_o, 50);
    chk("t100_last", last_count_o, 102);
    chk("t100_locked", locked_o, 1);
    chk("t100_t0_code", code_b, 50);
    chk("t100_t0_locked", locked_b, 0);

    begin_search(0, 2);
    run_to(N + 3, 1'b1);
    chk("t0_code", dco_code_o, 0);
    chk("t0_last", last_count_o, 2);
    chk("t0_locked", locked_o, 1);

    begin_search(65535, 2);
    run_to(N + 3, 1'b1);
    chk("tmax_code", dco_code_o, 255);
    chk("tmax_last", last_count_o, 510);
    chk("tmax_locked", locked_o, 0);
    chk("tmax_t0_code", code_b, 255);
    chk("tmax_t0_sat_last", last_b, 255);
    chk("tmax_t0_locked", locked_b, 1);

    begin_search(101, 2);
    run_to(N + 3, 1'b1);
    chk("t101_code", dco_code_o, 50);
    chk("t101_locked", locked_o, 1);
    chk("t101_t0_code", code_b, 50);
    chk("t101_t0_locked", locked_b, 0);

    // Abort in the bit-4 measurement window.
    nd0 = n_done;
    begin_search(100, 2);
    run_to(3 * P + S + 100, 1'b0);
    abort = 1'b1;
    m_ab = cyc - m_s0;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_code", dco_code_o, 8'h30);
    chk("abort_locked", locked_o, 0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    repeat (20) tick();
    chk("abort_start_busy", busy_o, 0);
    chk("abort_no_done", n_done - nd0, 0);

    // Synchronous reset mid-search, then a fresh search.
    begin_search(int'($urandom_range(0, 500)), 2);
    run_to(1000, 1'b0);
    rst = 1'b1;
    m_act = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_rst_code", dco_code_o, 0);
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_last", last_count_o, 0);
    chk("mid_rst_locked", locked_o, 0);
    repeat (8) tick();
    begin_search(200, 2);
    run_to(N + 3, 1'b0);
    chk("post_rst_done_cycle", last_done - m_s0, 4241);
    chk("post_rst_code", dco_code_o, 100);
    chk("post_rst_locked", locked_o, 1);

    for (int i = 0; i < 3; i++) begin
      t_r = int'($urandom_range(0, 560));
      g_r = int'($urandom_range(1, 2));
      begin_search(t_r, g_r);
      run_to(N + 3, 1'b1);
    end
`endif

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
